// File: rtl/fp_mul_pkg.sv
// Shared types for the pipelined floating-point multiplier: operand classes,
// the exception flag bundle and the bit positions of each flag.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    // Bit order matches the flags port: {invalid, overflow, underflow, inexact}
    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/fp_mul_round.sv
// Combinational normalise / round-to-nearest-even / pack for a NORM x NORM
// product; results are never subnormal (tiny results flush to signed zero).
module fp_mul_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    sign_i,
    input  logic [EXP_W+1:0]        exp_i,
    input  logic [2*FRAC_W+1:0]     prod_i,
    output logic [EXP_W+FRAC_W:0]   res_o,
    output logic                    overflow_o,
    output logic                    underflow_o,
    output logic                    inexact_o
);

    localparam int PW = 2 * FRAC_W + 2;
    localparam logic [EXP_W+1:0] EXP_ONES = {2'b00, {EXP_W{1'b1}}};
    localparam logic [EXP_W+1:0] EXP_ZERO = '0;

    logic               msb;
    logic [PW-1:0]      norm;
    logic [FRAC_W:0]    mant;
    logic               guardBit;
    logic               stickyBit;
    logic               roundUp;
    logic [FRAC_W+1:0]  rounded;
    logic               carry;
    logic [FRAC_W-1:0]  fracOut;
    logic [EXP_W+1:0]   expAdj;

    // The product lies in [1,4); left-aligning it puts the hidden bit at the
    // top so mantissa, guard and sticky always come from the same positions.
    always_comb begin
        msb       = prod_i[PW-1];
        norm      = msb ? prod_i : {prod_i[PW-2:0], 1'b0};
        mant      = norm[PW-1:FRAC_W+1];
        guardBit  = norm[FRAC_W];
        stickyBit = |norm[FRAC_W-1:0];
        roundUp   = guardBit & (stickyBit | mant[0]);
        rounded   = {1'b0, mant} + {{(FRAC_W+1){1'b0}}, roundUp};
        carry     = rounded[FRAC_W+1];
        fracOut   = carry ? rounded[FRAC_W:1] : rounded[FRAC_W-1:0];
        expAdj    = exp_i + {{(EXP_W+1){1'b0}}, msb} + {{(EXP_W+1){1'b0}}, carry};

        overflow_o  = ($signed(expAdj) >= $signed(EXP_ONES));
        underflow_o = ($signed(expAdj) <= $signed(EXP_ZERO));
        inexact_o   = guardBit | stickyBit | overflow_o | underflow_o;

        res_o = {sign_i, expAdj[EXP_W-1:0], fracOut};
        if (overflow_o) begin
            res_o = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (underflow_o) begin
            res_o = {sign_i, {(EXP_W+FRAC_W){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready handshake.
// Define FP_MUL_FLAGS_EN to build the exception flag logic; otherwise flags is 0.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   op,
    output logic [3:0]              flags
);

    localparam int SW = FRAC_W + 1;
    localparam int PW = 2 * FRAC_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] BIAS = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W+FRAC_W:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
        if (&e) begin
            return (|f) ? NAN : INF;
        end
        if (e == '0) begin
            return ZERO;
        end
        return NORM;
    endfunction

    logic adv;

    logic               s1Valid_q, s1Valid_d;
    logic               s1Sign_q, s1Sign_d;
    fp_class_e          s1ClassA_q, s1ClassA_d;
    fp_class_e          s1ClassB_q, s1ClassB_d;
    logic [XW-1:0]      s1Exp_q, s1Exp_d;
    logic [SW-1:0]      s1SigA_q, s1SigA_d;
    logic [SW-1:0]      s1SigB_q, s1SigB_d;

    logic               s2Valid_q, s2Valid_d;
    logic               s2Sign_q, s2Sign_d;
    fp_class_e          s2ClassA_q, s2ClassA_d;
    fp_class_e          s2ClassB_q, s2ClassB_d;
    logic [XW-1:0]      s2Exp_q, s2Exp_d;
    logic [PW-1:0]      s2Prod_q, s2Prod_d;

    logic                   outValid_q, outValid_d;
    logic [EXP_W+FRAC_W:0]  op_q, op_d;

    logic [EXP_W+FRAC_W:0]  roundRes;
    logic                   roundOvf;
    logic                   roundUnf;
    logic                   roundInexact;
    logic                   isNan;
    logic                   isInf;
    logic                   isZero;

    // The whole pipe moves together; only a stalled output holds it back.
    assign adv       = !outValid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = outValid_q;
    assign op        = op_q;

    always_comb begin
        s1Valid_d  = in_valid;
        s1Sign_d   = a[EXP_W+FRAC_W] ^ b[EXP_W+FRAC_W];
        s1ClassA_d = classify(a[EXP_W+FRAC_W-1:FRAC_W], a[FRAC_W-1:0]);
        s1ClassB_d = classify(b[EXP_W+FRAC_W-1:FRAC_W], b[FRAC_W-1:0]);
        s1Exp_d    = {2'b00, a[EXP_W+FRAC_W-1:FRAC_W]} + {2'b00, b[EXP_W+FRAC_W-1:FRAC_W]} - BIAS;
        s1SigA_d   = {1'b1, a[FRAC_W-1:0]};
        s1SigB_d   = {1'b1, b[FRAC_W-1:0]};
    end

    always_comb begin
        s2Valid_d  = s1Valid_q;
        s2Sign_d   = s1Sign_q;
        s2ClassA_d = s1ClassA_q;
        s2ClassB_d = s1ClassB_q;
        s2Exp_d    = s1Exp_q;
        s2Prod_d   = {{SW{1'b0}}, s1SigA_q} * {{SW{1'b0}}, s1SigB_q};
    end

    fp_mul_round #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) roundUnit (
        .sign_i      (s2Sign_q),
        .exp_i       (s2Exp_q),
        .prod_i      (s2Prod_q),
        .res_o       (roundRes),
        .overflow_o  (roundOvf),
        .underflow_o (roundUnf),
        .inexact_o   (roundInexact)
    );

    // Special operands override the rounded NORM x NORM result, NaN first.
    always_comb begin
        isNan  = (s2ClassA_q == NAN) || (s2ClassB_q == NAN) ||
                 ((s2ClassA_q == INF) && (s2ClassB_q == ZERO)) ||
                 ((s2ClassA_q == ZERO) && (s2ClassB_q == INF));
        isInf  = (s2ClassA_q == INF) || (s2ClassB_q == INF);
        isZero = (s2ClassA_q == ZERO) || (s2ClassB_q == ZERO);

        outValid_d = s2Valid_q;
        op_d       = roundRes;
        if (isNan) begin
            op_d = QNAN;
        end else if (isInf) begin
            op_d = {s2Sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (isZero) begin
            op_d = {s2Sign_q, {(EXP_W+FRAC_W){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q  <= 1'b0;
            s1Sign_q   <= 1'b0;
            s1ClassA_q <= ZERO;
            s1ClassB_q <= ZERO;
            s1Exp_q    <= '0;
            s1SigA_q   <= '0;
            s1SigB_q   <= '0;
            s2Valid_q  <= 1'b0;
            s2Sign_q   <= 1'b0;
            s2ClassA_q <= ZERO;
            s2ClassB_q <= ZERO;
            s2Exp_q    <= '0;
            s2Prod_q   <= '0;
            outValid_q <= 1'b0;
            op_q       <= '0;
        end else if (adv) begin
            s1Valid_q  <= s1Valid_d;
            s1Sign_q   <= s1Sign_d;
            s1ClassA_q <= s1ClassA_d;
            s1ClassB_q <= s1ClassB_d;
            s1Exp_q    <= s1Exp_d;
            s1SigA_q   <= s1SigA_d;
            s1SigB_q   <= s1SigB_d;
            s2Valid_q  <= s2Valid_d;
            s2Sign_q   <= s2Sign_d;
            s2ClassA_q <= s2ClassA_d;
            s2ClassB_q <= s2ClassB_d;
            s2Exp_q    <= s2Exp_d;
            s2Prod_q   <= s2Prod_d;
            outValid_q <= outValid_d;
            op_q       <= op_d;
        end
    end

`ifdef FP_MUL_FLAGS_EN
    fp_flags_t flags_q, flags_d;

    // Range flags only apply when the rounded path actually produced op.
    always_comb begin
        flags_d = '0;
        if (isNan) begin
            flags_d.invalid = 1'b1;
        end else if (!isInf && !isZero) begin
            flags_d.overflow  = roundOvf;
            flags_d.underflow = roundUnf;
            flags_d.inexact   = roundInexact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (adv) begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    logic unusedFlags;
    assign unusedFlags = roundOvf ^ roundUnf ^ roundInexact;
    assign flags       = 4'b0000;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe (FP32): special values, rounding, range
// limits, latency, backpressure ordering and mid-stream reset.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

`ifdef FP_MUL_FLAGS_EN
    localparam logic [3:0] FLAG_MASK = 4'hF;
`else
    localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

    fp_mul_pipe #(
        .EXP_W  (8),
        .FRAC_W (23)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op        (op),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One isolated operation: checks acceptance, exact 3-cycle latency and the result.
    task automatic applyStimulus(input string tag, input logic [31:0] va, input logic [31:0] vb,
                                 input logic [31:0] expOp, input logic [3:0] expFlags);
        @(negedge clk);
        a         = va;
        b         = vb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        checkOutput({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        checkOutput({tag, " valid@1"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1 checkOutput({tag, " valid@2"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1 checkOutput({tag, " valid@3"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, " op"}, op, expOp);
        checkOutput({tag, " flags"}, {28'b0, flags}, {28'b0, expFlags & FLAG_MASK});
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bpExp [10];
    logic [15:0] readyPat;
    logic [31:0] heldOp;
    logic        held;
    int          sent;
    int          recv;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #2;
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset op", op, 32'h0);
        checkOutput("reset flags", {28'b0, flags}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("release in_ready", {31'b0, in_ready}, 32'd1);

        applyStimulus("basic", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        applyStimulus("inf*zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        applyStimulus("-inf*one", 32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000);
        applyStimulus("nan*one", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        applyStimulus("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
        applyStimulus("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
        applyStimulus("sticky", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        applyStimulus("subnormal", 32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);
        applyStimulus("negative", 32'hBF800000, 32'h40400000, 32'hC0400000, 4'b0000);
        applyStimulus("msb-norm", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001);
        applyStimulus("tie-up", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
        applyStimulus("tie-even", 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001);

        // Backpressure: operand i times 2.0 only bumps the exponent by one.
        for (int i = 0; i < 10; i++) begin
            bpExp[i] = 32'h3F800000 + 32'(i) * 32'h00080000 + 32'h00800000;
        end
        readyPat = 16'b0110_1001_1100_1011;
        held = 1'b0;
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
            out_ready = readyPat[cyc % 16];
            if (sent < 10) begin
                a        = 32'h3F800000 + 32'(sent) * 32'h00080000;
                b        = 32'h40000000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (held) begin
                checkOutput("bp held valid", {31'b0, out_valid}, 32'd1);
                checkOutput("bp held op", op, heldOp);
                held = 1'b0;
            end
            if (out_valid && !out_ready) begin
                held   = 1'b1;
                heldOp = op;
                checkOutput("bp stall in_ready", {31'b0, in_ready}, 32'd0);
            end
            if (out_valid && out_ready) begin
                if (recv < 10) begin
                    checkOutput("bp result", op, bpExp[recv]);
                    checkOutput("bp flags", {28'b0, flags}, 32'h0);
                end else begin
                    checkOutput("bp extra result", 32'(recv), 32'd9);
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("bp received", 32'(recv), 32'd10);
        checkOutput("bp sent", 32'(sent), 32'd10);
        checkOutput("bp drained", {31'b0, out_valid}, 32'd0);

        // Mid-stream reset with three operations stalled in the pipe.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 32'h40000000;
        b         = 32'h40000000;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        checkOutput("pre-reset valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid-reset valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mid-reset op", op, 32'h0);
        checkOutput("mid-reset flags", {28'b0, flags}, 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        checkOutput("post-reset in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 checkOutput("post-reset stale", {31'b0, out_valid}, 32'd0);
        end
        applyStimulus("post-reset", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
